// File: rtl/clock_pkg.sv
// Shared definitions for the clock tick generator: FSM state encoding,
// default divider constants and a counter-width helper.
package clock_pkg;

  // Operating modes of the tick generator
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_MIN = 2'd1,
    ST_SET_HR  = 2'd2
  } state_t;

  // Defaults assume a ~50 MHz system clock
  localparam int unsigned DEF_CLK_DIV         = 50_000_000;  // 1 Hz seconds tick
  localparam int unsigned DEF_FAST_DIV        = 5_000_000;   // 10 Hz fast-set tick
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms button settle

  // Width of a counter that runs 0..n-1; never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button conditioning: two-flop synchroniser followed by a debouncer
// that only accepts a new level after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles.
module button_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_level;
  logic [W-1:0] r_cnt;

  // Synchronise the asynchronous input, then count consecutive cycles the
  // synchronised level disagrees with the accepted level; any agreement
  // (a bounce back) restarts the count.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/clock_tick_gen.sv
// Tick generator for a digital clock: a seconds prescaler in normal
// running, and fast-set ticks for minutes/hours while a set button is held.
module clock_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV         = DEF_CLK_DIV,
  parameter int unsigned FAST_DIV        = DEF_FAST_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_btn_min,
  input  logic i_btn_hr,
  output logic o_sec_tick,
  output logic o_min_set_tick,
  output logic o_hr_set_tick,
  output logic o_setting
);

  localparam int unsigned PW = cnt_width(CLK_DIV);
  localparam int unsigned FW = cnt_width(FAST_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

  // Index 0 = minute button, index 1 = hour button
  logic [1:0] w_btn_raw;
  logic [1:0] w_db_level;

  assign w_btn_raw = {i_btn_hr, i_btn_min};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_sysclk(i_sysclk),
        .i_reset (i_reset),
        .i_btn   (w_btn_raw[gi]),
        .o_level (w_db_level[gi])
      );
    end
  endgenerate

  logic w_db_min;
  logic w_db_hr;
  assign w_db_min = w_db_level[0];
  assign w_db_hr  = w_db_level[1];

  state_t        r_state;
  logic [PW-1:0] r_prescaler;
  logic [FW-1:0] r_fast_cnt;
  logic          r_sec_tick;
  logic          r_min_set_tick;
  logic          r_hr_set_tick;
  logic          r_setting;

  // Mode FSM with prescalers and registered tick outputs. Ticks default to
  // 0 each cycle so none can be wider than one cycle, and each state drives
  // at most one of them. The fast counter is 0 on entry to a set state, so
  // the first set tick lands the cycle after entry.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state        <= ST_RUN;
      r_prescaler    <= '0;
      r_fast_cnt     <= '0;
      r_sec_tick     <= 1'b0;
      r_min_set_tick <= 1'b0;
      r_hr_set_tick  <= 1'b0;
      r_setting      <= 1'b0;
    end else begin
      r_sec_tick     <= 1'b0;
      r_min_set_tick <= 1'b0;
      r_hr_set_tick  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_db_hr) begin
            // Hour wins a simultaneous press
            r_state     <= ST_SET_HR;
            r_setting   <= 1'b1;
            r_prescaler <= '0;
            r_fast_cnt  <= '0;
          end else if (w_db_min) begin
            r_state     <= ST_SET_MIN;
            r_setting   <= 1'b1;
            r_prescaler <= '0;
            r_fast_cnt  <= '0;
          end else if (i_en) begin
            if (r_prescaler == PRE_LAST) begin
              r_prescaler <= '0;
              r_sec_tick  <= 1'b1;
            end else begin
              r_prescaler <= r_prescaler + 1'b1;
            end
          end
        end
        ST_SET_MIN: begin
          r_prescaler <= '0;
          if (!w_db_min) begin
            r_state    <= ST_RUN;
            r_setting  <= 1'b0;
            r_fast_cnt <= '0;
          end else begin
            r_min_set_tick <= (r_fast_cnt == '0);
            r_fast_cnt     <= (r_fast_cnt == FAST_LAST) ? '0 : r_fast_cnt + 1'b1;
          end
        end
        ST_SET_HR: begin
          r_prescaler <= '0;
          if (!w_db_hr) begin
            r_state    <= ST_RUN;
            r_setting  <= 1'b0;
            r_fast_cnt <= '0;
          end else begin
            r_hr_set_tick <= (r_fast_cnt == '0);
            r_fast_cnt    <= (r_fast_cnt == FAST_LAST) ? '0 : r_fast_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_setting   <= 1'b0;
          r_prescaler <= '0;
          r_fast_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_sec_tick     = r_sec_tick;
  assign o_min_set_tick = r_min_set_tick;
  assign o_hr_set_tick  = r_hr_set_tick;
  assign o_setting      = r_setting;

endmodule
